// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 16-deep byte FIFO feeding a runtime-configurable UART serializer.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   wr_en, wr_data    push one byte into the FIFO (dropped while full)
//   parity            0/3 none, 1 even, 2 odd (honoured only with UART_TX_PARITY_EN)
//   stop_sel          0 = one stop bit, 1 = two stop bits
//   baudcontrol       bit period minus one, in clk cycles
//   tx                serial line, idle high, LSB first
//   busy              frame in progress
//   full, empty       FIFO occupancy flags
//   count             FIFO occupancy
//   overflow          one-cycle pulse when a write is dropped
//   frame_done        one-cycle pulse during the last cycle of the last stop bit
// Build option: define UART_TX_PARITY_EN to add the parity bit and PARITY state;
// without it the parity input is ignored and frames are 8N1/8N2.
module uart_tx_buffered #(
   parameter int DEPTH      = 16,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [7:0]          wr_data,
   input  logic [1:0]          parity,
   input  logic                stop_sel,
   input  logic [23:0]         baudcontrol,
   output logic                tx,
   output logic                busy,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_LOG2:0] count,
   output logic                overflow,
   output logic                frame_done
);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP1,
      STOP2
   } state_t;

   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_q, wr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  full_q, empty_q, ovf_q, push, pop;
   state_t                state_q, after_data;
   logic [7:0]            data_q;
   logic [2:0]            bit_q;
   logic [23:0]           cnt_q, bc_q;
   logic                  stop_q, tx_q, tx_d, busy_q, done_q, bit_end;

   assign push    = wr_en && !full_q;
   assign pop     = state_q == IDLE && !empty_q;
   assign count_d = count_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
   assign bit_end = cnt_q == bc_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wr_q <= wr_q + DEPTH_LOG2'(1);
         if (pop) rd_q <= rd_q + DEPTH_LOG2'(1);
         count_q <= count_d;
         full_q  <= count_d == FULL_CNT;
         empty_q <= count_d == '0;
         ovf_q   <= wr_en && full_q;
      end
   end

   // Head byte and frame format are captured together at pop so that config
   // changes mid-frame only affect the next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         bc_q   <= '0;
         stop_q <= 1'b0;
      end else if (pop) begin
         data_q <= mem_q[rd_q];
         bc_q   <= baudcontrol;
         stop_q <= stop_sel;
      end
   end

`ifdef UART_TX_PARITY_EN
   logic [1:0] par_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) par_q <= '0;
      else if (pop) par_q <= parity;
   end

   // par_q 1 (even) sends XOR(data), 2 (odd) inverts it; ^par_q is true only for 1 and 2.
   assign after_data = ^par_q ? PARITY : STOP1;
   assign tx_d = state_q == START  ? 1'b0 :
                 state_q == DATA   ? data_q[bit_q] :
                 state_q == PARITY ? ^data_q ^ par_q[1] : 1'b1;
`else
   logic unused_parity;

   assign unused_parity = ^parity;
   assign after_data    = STOP1;
   assign tx_d = state_q == START ? 1'b0 :
                 state_q == DATA  ? data_q[bit_q] : 1'b1;
`endif

   // tx and busy are registered from the current state, so the line trails the
   // state by one cycle; frame_done is aligned with the last tx stop cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= '0;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= state_q != IDLE;
         done_q <= bit_end && (state_q == STOP2 || (state_q == STOP1 && !stop_q));
         cnt_q  <= (bit_end || state_q == IDLE) ? '0 : cnt_q + 24'd1;
         if (state_q == DATA && bit_end) bit_q <= bit_q + 3'd1;
         case (state_q)
            IDLE:    if (!empty_q) state_q <= START;
            START:   if (bit_end) state_q <= DATA;
            DATA:    if (bit_end && bit_q == 3'd7) state_q <= after_data;
`ifdef UART_TX_PARITY_EN
            PARITY:  if (bit_end) state_q <= STOP1;
`endif
            STOP1:   if (bit_end) state_q <= stop_q ? STOP2 : IDLE;
            STOP2:   if (bit_end) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign full       = full_q;
   assign empty      = empty_q;
   assign count      = count_q;
   assign overflow   = ovf_q;
   assign frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench; a line monitor decodes every frame on tx cycle by cycle.
module tb_uart_tx_buffered;
   logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, stop_sel = 1'b0;
   logic [7:0]  wr_data = '0;
   logic [1:0]  parity = '0;
   logic [23:0] baudcontrol = 24'd3;
   logic        tx, busy, full, empty, overflow, frame_done;
   logic [4:0]  count;
   int          checks = 0, errors = 0;
   logic [7:0]  exp_q[$];
   bit          mon_active = 1'b0, expect_start = 1'b0;

   always #5 clk = ~clk;

   uart_tx_buffered dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .parity(parity),
      .stop_sel(stop_sel), .baudcontrol(baudcontrol), .tx(tx), .busy(busy),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .frame_done(frame_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected frame = start 0, 8 data bits LSB first, optional parity, 1 or 2 stop
   // bits, each (baudcontrol+1) cycles; format taken from the inputs at frame start.
   task automatic frame_check();
      logic [7:0]  d;
      logic [11:0] bits;
      logic        exp_tx;
      int          b, n, pb, bad, fd_bad;
      mon_active = 1'b1;
      bad = 0;
      fd_bad = 0;
      b = int'(baudcontrol) + 1;
      pb = 0;
`ifdef UART_TX_PARITY_EN
      pb = (parity == 2'd1 || parity == 2'd2) ? 1 : 0;
`endif
      n = 10 + pb + int'(stop_sel);
      check("frame expected", exp_q.size() > 0, 1);
      d = exp_q.size() > 0 ? exp_q.pop_front() : 8'h00;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      if (pb == 1) bits[9] = parity == 2'd1 ? ^d : ~^d;
      for (int c = 0; c <= n * b; c++) begin
         if (rst) begin
            mon_active = 1'b0;
            return;
         end
         exp_tx = c < n * b ? bits[c / b] : 1'b1;
         if (tx !== exp_tx) bad++;
         if (frame_done !== (c == n * b - 1)) fd_bad++;
         if (c < n * b) @(negedge clk);
      end
      check($sformatf("frame %02h bad tx cycles", d), bad, 0);
      check($sformatf("frame %02h bad frame_done cycles", d), fd_bad, 0);
      expect_start = exp_q.size() > 0;
      mon_active = 1'b0;
   endtask

   initial forever begin
      @(negedge clk);
      if (expect_start) begin
         expect_start = 1'b0;
         check("single idle cycle between frames", tx, 1'b0);
      end
      if (!rst && tx === 1'b0) frame_check();
   end

   task automatic send(input logic [7:0] d);
      wr_en = 1'b1;
      wr_data = d;
      exp_q.push_back(d);
      @(posedge clk);
      #1 wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || mon_active || busy) && t < limit) begin
         @(negedge clk);
         t++;
      end
      check("drain within cycle budget", t >= limit, 1'b0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int         occ, t, hi_bad;
      bit         acc;
      logic [7:0] d;
      repeat (3) @(posedge clk);
      #1;
      check("reset tx", tx, 1'b1);
      check("reset busy", busy, 1'b0);
      check("reset full", full, 1'b0);
      check("reset empty", empty, 1'b1);
      check("reset count", count, 0);
      check("reset overflow", overflow, 1'b0);
      check("reset frame_done", frame_done, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // First-byte latency and a long 8N1 frame.
      baudcontrol = 24'd867;
      wr_en = 1'b1;
      wr_data = 8'h55;
      exp_q.push_back(8'h55);
      @(posedge clk);
      #1 wr_en = 1'b0;
      check("empty after push", empty, 1'b0);
      check("count after push", count, 1);
      check("tx idle after push", tx, 1'b1);
      @(posedge clk);
      #1;
      check("tx idle after pop", tx, 1'b1);
      check("busy low after pop", busy, 1'b0);
      check("count after pop", count, 0);
      @(posedge clk);
      #1;
      check("tx start bit", tx, 1'b0);
      check("busy in frame", busy, 1'b1);
      wait_idle(20000);

      // Parity frames, then 2-stop back-to-back frames.
      baudcontrol = 24'd3;
      parity = 2'd1;
      send(8'h07);
      wait_idle(2000);
      parity = 2'd2;
      send(8'h07);
      wait_idle(2000);
      parity = 2'd0;
      stop_sel = 1'b1;
      send(8'hA3);
      send(8'h3C);
      wait_idle(2000);
      stop_sel = 1'b0;

      // 18 consecutive writes: one popped early, 16 buffered, last one dropped.
      occ = 0;
      for (int k = 0; k < 18; k++) begin
         d = 8'($urandom);
         acc = occ < 16;
         wr_en = 1'b1;
         wr_data = d;
         if (acc) exp_q.push_back(d);
         @(posedge clk);
         #1;
         occ += int'(acc);
         if (k == 1) occ--;
         check($sformatf("burst overflow %0d", k), overflow, !acc);
         check($sformatf("burst count %0d", k), count, occ);
         check($sformatf("burst full %0d", k), full, occ == 16);
      end
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      check("overflow single pulse", overflow, 1'b0);
      wait_idle(5000);

      // Random formats, including 1-cycle bits.
      for (int r = 0; r < 8; r++) begin
         baudcontrol = r == 0 ? 24'd0 : 24'($urandom_range(1, 5));
         parity = 2'($urandom_range(0, 3));
         stop_sel = 1'($urandom_range(0, 1));
         for (int i = 0; i < int'($urandom_range(1, 4)); i++) send(8'($urandom));
         wait_idle(3000);
      end
      parity = 2'd0;
      stop_sel = 1'b0;

      // Baud change mid-frame applies to the next frame only.
      baudcontrol = 24'd867;
      send(8'($urandom));
      send(8'($urandom));
      repeat (3000) @(posedge clk);
      #1 baudcontrol = 24'd433;
      wait_idle(30000);

      // Reset during data bit 4 with more bytes buffered.
      baudcontrol = 24'd20;
      send(8'h5A);
      send(8'h11);
      send(8'h22);
      t = 0;
      while (tx !== 1'b0 && t < 10) begin
         @(posedge clk);
         #1 t++;
      end
      check("frame started before reset", tx, 1'b0);
      repeat (115) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async reset tx", tx, 1'b1);
      check("async reset busy", busy, 1'b0);
      check("async reset count", count, 0);
      check("async reset empty", empty, 1'b1);
      exp_q.delete();
      expect_start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      hi_bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) hi_bad++;
      end
      check("line idle after reset", hi_bad, 0);
      check("fifo empty after reset", count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3ms;
      errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
